tpu_result_drain: RTL and testbench

Read-side engine for the core's output buffer. It accepts a drain command (base address, row count), issues row reads on the output-buffer read port, and streams each W-lane int32 result row out on a valid/ready interface with backpressure. A small row FIFO with credit-based read issue means a row is never dropped, whatever the read latency or stall pattern.

---
 rtl/tpu_drain_pkg.sv | 20 ++
 rtl/drain_row_fifo.sv | 54 +++++
 rtl/tpu_result_drain.sv | 166 ++++++++++++++++
 tb/tb_tpu_result_drain.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_drain_pkg.sv
// Shared types and constants for the output-buffer result drain engine.
// Default shapes match a 16-lane int32 systolic array with a 1024-row buffer.
package tpu_drain_pkg;

    localparam int W_DFLT             = 16;
    localparam int ACC_W_DFLT         = 32;
    localparam int ADDR_W_DFLT        = 10;
    localparam int DRAIN_READ_LATENCY = 1;
    localparam int CNT_W              = ADDR_W_DFLT + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } drain_state_e;

    typedef logic [ACC_W_DFLT-1:0] row_t [W_DFLT];

endpackage

// File: rtl/drain_row_fifo.sv
// First-word-fall-through FIFO of W-lane result rows; the head row is visible
// combinationally while the FIFO is non-empty.
module drain_row_fifo #(
    parameter int W      = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data [W],
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data [W],
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH][W];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = count[PTR_W];
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]][gi] <= push_data[gi];
            end
        end
        assign pop_data[gi] = mem_q[rd_ptr_q[PTR_W-1:0]][gi];
    end

endmodule

// File: rtl/tpu_result_drain.sv
// Drains rows from the output buffer to a valid/ready stream using credit-gated reads.
// Optional DRAIN_STALL_CNT_EN adds a per-command backpressure cycle counter.
module tpu_result_drain
    import tpu_drain_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = W_DFLT,
    parameter int DATA_WIDTH_ACCUM     = ACC_W_DFLT,
    parameter int ADDR_WIDTH           = ADDR_W_DFLT,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_WIDTH-1:0]       cmd_base_addr,
    input  logic [ADDR_WIDTH:0]         cmd_num_rows,
    output logic [ADDR_WIDTH-1:0]       ob_rd_addr,
    output logic                        ob_rd_en,
    input  logic [DATA_WIDTH_ACCUM-1:0] ob_rd_data [SYSTOLIC_ARRAY_WIDTH],
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH_ACCUM-1:0] m_data [SYSTOLIC_ARRAY_WIDTH],
    output logic                        m_last,
    output logic                        busy,
    output logic                        done
`ifdef DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);
    localparam int BEAT_W = ADDR_WIDTH + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W  = FCNT_W + 1;

    drain_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [BEAT_W-1:0]             rd_left_q, rd_left_d;
    logic [BEAT_W-1:0]             beat_left_q, beat_left_d;
    logic [DRAIN_READ_LATENCY-1:0] inflight_q, inflight_d;

    logic [FCNT_W-1:0]             fifo_count;
    logic [OCC_W-1:0]              occupancy;
    logic                          fifo_empty, fifo_full, fifo_pop;
    logic                          credit_ok, cmd_fire, rd_fire;
    logic [DATA_WIDTH_ACCUM-1:0]   head [SYSTOLIC_ARRAY_WIDTH];

    assign cmd_ready  = (state_q == IDLE) & ~rst;
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign m_valid    = ~fifo_empty;
    assign fifo_pop   = m_valid & m_ready;
    assign m_last     = m_valid & (beat_left_q == BEAT_W'(1));
    assign ob_rd_en   = rd_fire;
    assign ob_rd_addr = addr_q;

    // Rows already stored plus rows still on their way from the buffer must fit.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < DRAIN_READ_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(inflight_q[i]);
        end
    end

    assign credit_ok = fifo_pop | (~fifo_full & (occupancy < OCC_W'(FIFO_DEPTH)));
    assign rd_fire   = (state_q == RUN) & credit_ok;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_left_d     = rd_left_q;
        beat_left_d   = beat_left_q;
        inflight_d    = inflight_q << 1;
        inflight_d[0] = rd_fire;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d      = cmd_base_addr;
                    rd_left_d   = cmd_num_rows;
                    beat_left_d = cmd_num_rows;
                    state_d     = (cmd_num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_fire) begin
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rd_left_d = rd_left_q - BEAT_W'(1);
                    if (rd_left_q == BEAT_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (fifo_pop && m_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fifo_pop) begin
            beat_left_d = beat_left_q - BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_left_q   <= '0;
            beat_left_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            beat_left_q <= beat_left_d;
            inflight_q  <= inflight_d;
        end
    end

    drain_row_fifo #(
        .W      (SYSTOLIC_ARRAY_WIDTH),
        .DATA_W (DATA_WIDTH_ACCUM),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q[DRAIN_READ_LATENCY-1]),
        .push_data (ob_rd_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Stale FIFO slots must not leak onto the bus while nothing is valid.
    for (genvar gi = 0; gi < SYSTOLIC_ARRAY_WIDTH; gi++) begin : g_out
        assign m_data[gi] = fifo_empty ? '0 : head[gi];
    end

`ifdef DRAIN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cmd_fire) begin
            stall_cnt_d = '0;
        end else if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: directed drain commands, monitor-side checking.
`timescale 1ns/1ps
module tb_tpu_result_drain;
    import tpu_drain_pkg::*;

    localparam int W     = 16;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    typedef struct {
        int   addr;
        logic last;
    } exp_beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base_addr;
    logic [CNT_W-1:0] cmd_num_rows;
    logic [AW-1:0]    ob_rd_addr;
    logic             ob_rd_en;
    row_t             ob_rd_data;
    logic             m_valid;
    logic             m_ready;
    row_t             m_data;
    logic             m_last;
    logic             busy;
    logic             done;
`ifdef DRAIN_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    tpu_result_drain #(
        .SYSTOLIC_ARRAY_WIDTH (W),
        .DATA_WIDTH_ACCUM     (DW),
        .ADDR_WIDTH           (AW),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_num_rows  (cmd_num_rows),
        .ob_rd_addr    (ob_rd_addr),
        .ob_rd_en      (ob_rd_en),
        .ob_rd_data    (ob_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done)
`ifdef DRAIN_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cmd_seq = 0;
    int mon_seq = 0;
    exp_beat_t exp_q[$];
    int        exp_rd_q[$];
    int issued = 0, popped = 0;
    int first_rd = -1, last_rd = -1, first_vld = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
    row_t held;
    logic held_v = 1'b0;
    int   pat [6] = '{1, 0, 0, 1, 0, 1};

    function automatic logic [DW-1:0] lane_val(input int addr, input int lane);
        return DW'((32'h1000 * addr) + lane);
    endfunction

    function automatic row_t make_row(input int addr);
        row_t r;
        for (int l = 0; l < W; l++) r[l] = lane_val(addr, l);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string name, input row_t got, input row_t exp);
        int bad;
        bad = -1;
        for (int l = W - 1; l >= 0; l--) if (got[l] !== exp[l]) bad = l;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: lane %0d got %0h expected %0h (cycle %0d)",
                     name, bad, got[bad], exp[bad], cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output buffer model: registered read, data valid one cycle after ob_rd_en.
    always @(posedge clk) begin
        if (ob_rd_en) begin
            for (int l = 0; l < W; l++) ob_rd_data[l] <= lane_val(int'(ob_rd_addr), l);
        end
    end

    // Monitor: samples on the falling edge, between stimulus updates and the active edge.
    always @(negedge clk) begin
        exp_beat_t e;
        if (mon_seq != cmd_seq) begin
            mon_seq   = cmd_seq;
            first_rd  = -1;
            last_rd   = -1;
            first_vld = -1;
            last_hs   = -1;
            done_cyc  = -1;
            done_cnt  = 0;
        end
        if (rst) begin
            exp_q.delete();
            exp_rd_q.delete();
            issued = 0;
            popped = 0;
            held_v = 1'b0;
        end else begin
            if (ob_rd_en) begin
                issued++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got read at %0d required none", ob_rd_addr);
                end else begin
                    chk("rd_addr", 64'(ob_rd_addr), 64'(exp_rd_q.pop_front()));
                end
            end
            if (m_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (held_v) chk_row("stall_stable", m_data, held);
            end
            if (m_valid && m_ready) begin
                popped++;
                last_hs = cyc;
                held_v  = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got row lane0 %0h required none", m_data[0]);
                end else begin
                    e = exp_q.pop_front();
                    chk_row("row_data", m_data, make_row(e.addr));
                    chk("row_last", 64'(m_last), 64'(e.last));
                end
            end else if (m_valid) begin
                held   = m_data;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (ob_rd_en) chk("fifo_bound", 64'((issued - popped) <= DEPTH), 64'(1));
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    // mode 0: always ready; 1: ready pattern 1,0,0,1,0,1; 2: five stall cycles once valid.
    task automatic run_cmd(input int base, input int rows, input int mode, output int accept);
        exp_beat_t b;
        int k;
        int stalls;
        k      = 0;
        stalls = 5;
        cmd_seq++;
        for (int i = 0; i < rows; i++) begin
            b.addr = (base + i) % 1024;
            b.last = (i == rows - 1);
            exp_q.push_back(b);
            exp_rd_q.push_back(b.addr);
        end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid     = 1'b1;
        cmd_base_addr = AW'(base);
        cmd_num_rows  = CNT_W'(rows);
        m_ready       = 1'b1;
        @(posedge clk); #1;
        accept    = cyc;
        cmd_valid = 1'b0;
        chk("cmd_ready_drop", 64'(cmd_ready), 64'(0));
        chk("busy_set", 64'(busy), 64'(1));
        while (done_cyc < 0 && k < 400) begin
            case (mode)
                1: m_ready = pat[k % 6][0];
                2: begin
                    if (m_valid && stalls > 0) begin
                        m_ready = 1'b0;
                        stalls--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            k++;
        end
        m_ready = 1'b1;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles required done", k);
        end
        chk("done_single", 64'(done), 64'(0));
        chk("idle_ready", 64'(cmd_ready), 64'(1));
        chk("busy_clear", 64'(busy), 64'(0));
        chk("rows_drained", 64'(exp_q.size()), 64'(0));
        chk("reads_drained", 64'(exp_rd_q.size()), 64'(0));
        chk("done_count", 64'(done_cnt), 64'(1));
        $display("cmd base=%0d rows=%0d mode=%0d accept=%0d done=%0d", base, rows, mode, accept, done_cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        row_t z;
        for (int l = 0; l < W; l++) z[l] = '0;
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_done"},      64'(done),      64'(0));
        chk({tag, "_m_valid"},   64'(m_valid),   64'(0));
        chk({tag, "_m_last"},    64'(m_last),    64'(0));
        chk({tag, "_rd_en"},     64'(ob_rd_en),  64'(0));
        chk({tag, "_rd_addr"},   64'(ob_rd_addr), 64'(0));
        chk_row({tag, "_m_data"}, m_data, z);
    endtask

    initial begin
        int acc;
        int p0;
        int k;
        exp_beat_t b;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_base_addr = '0;
        cmd_num_rows  = '0;
        m_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("reset_release_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;

        // 1: four rows, back-to-back reads and beats.
        run_cmd(5, 4, 0, acc);
        chk("t1_first_rd",  64'(first_rd),  64'(acc));
        chk("t1_last_rd",   64'(last_rd),   64'(acc + 3));
        chk("t1_first_vld", 64'(first_vld), 64'(acc + 2));
        chk("t1_last_hs",   64'(last_hs),   64'(acc + 5));
        chk("t1_done",      64'(done_cyc),  64'(acc + 6));

        // 2: eight rows under an irregular ready pattern.
        run_cmd(12'h100, 8, 1, acc);

        // 3: address wrap at the top of the buffer.
        run_cmd(1022, 4, 0, acc);

        // 4: empty command.
        run_cmd(7, 0, 0, acc);
        chk("t4_no_rd",    64'(first_rd),  64'(-1));
        chk("t4_no_valid", 64'(first_vld), 64'(-1));
        chk("t4_done",     64'(done_cyc),  64'(acc));

        // 5: reset after three of ten rows, then a clean two-row command.
        cmd_seq++;
        p0 = popped;
        for (int i = 0; i < 10; i++) begin
            b.addr = 12'h040 + i;
            b.last = (i == 9);
            exp_q.push_back(b);
            exp_rd_q.push_back(b.addr);
        end
        cmd_valid     = 1'b1;
        cmd_base_addr = AW'(12'h040);
        cmd_num_rows  = CNT_W'(10);
        m_ready       = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while ((popped - p0) < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if ((popped - p0) < 3) begin
            checks++;
            errors++;
            $display("FAIL t5_timeout: got %0d beats required 3", popped - p0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midrst");
        rst = 1'b0;
        #1;
        chk("midrst_idle_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        run_cmd(12'h200, 2, 0, acc);

        // 6: five stall cycles, then a fresh command.
        run_cmd(12'h300, 4, 2, acc);
`ifdef DRAIN_STALL_CNT_EN
        chk("t6_stall_cnt", 64'(stall_cnt), 64'(5));
        run_cmd(12'h310, 1, 0, acc);
        chk("t6_stall_clear", 64'(stall_cnt), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish by 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
